// File: rtl/nbit_counter_dec.sv
// Loadable N-bit down-counter/timer with start/stop control, terminal-count
// done pulse and optional auto-reload for periodic operation.
module nbit_counter_dec #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         start,
   input  logic         stop,
   input  logic         dec,
   input  logic         reload_en,
   output logic [N-1:0] count,
   output logic         busy,
   output logic         zero,
   output logic         done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e       state_q, state_d;
   logic [N-1:0] count_q, count_d;
   logic [N-1:0] reload_q, reload_d;
   logic         done_q, done_d;

   // State, count, reload value and done pulse registers; synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   // Next-state decode: load > stop > start > dec.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;

      if (load) begin
         // Load aborts any run silently and rearms the reload value.
         count_d  = load_val;
         reload_d = load_val;
         state_d  = IDLE;
      end else if (stop) begin
         // Stop also masks a same-edge start while idle.
         state_d = IDLE;
      end else if (start && (state_q == IDLE)) begin
         // Starting at zero would immediately underflow, so it is ignored.
         if (count_q != '0) begin
            state_d = RUN;
         end
      end else if (dec && (state_q == RUN)) begin
         if (count_q == N'(1)) begin
            done_d = 1'b1;
            if (reload_en) begin
               count_d = reload_q;
            end else begin
               count_d = '0;
               state_d = IDLE;
            end
         end else if (count_q != '0) begin
            count_d = count_q - N'(1);
         end
      end
   end

   assign count = count_q;
   assign busy  = (state_q == RUN);
   assign done  = done_q;
   assign zero  = (count_q == '0);

endmodule
